// File: rtl/display_pkg.sv
// Shared constants and types for the display sequencer: config bit layout,
// pipeline geometry and the world-map tile address helper.
package display_pkg;

    localparam int unsigned PIPE_LATENCY = 3;
    localparam int unsigned TILE_SHIFT   = 3;
    localparam int unsigned COORD_W      = 10;
    localparam int unsigned TILE_W       = COORD_W - TILE_SHIFT;
    localparam int unsigned ADDR_W       = 2 * TILE_W;
    localparam int unsigned PIX_W        = 2;
    localparam int unsigned FRAME_W      = 8;
    localparam int unsigned BLINK_BIT    = 5;

    localparam int unsigned CFG_W        = 4;
    localparam int unsigned CFG_ICON0_EN = 0;
    localparam int unsigned CFG_ICON1_EN = 1;
    localparam int unsigned CFG_PRIO     = 2;
    localparam int unsigned CFG_BLINK    = 3;

    localparam logic [CFG_W-1:0] CFG_RESET  = 4'b0011;
    localparam logic [CFG_W-1:0] SHADOW_RST = 4'b0000;

    // Field order mirrors the CFG_* bit indices (icon0_en is bit 0).
    typedef struct packed {
        logic icon1_blink;
        logic prio;
        logic icon1_en;
        logic icon0_en;
    } cfg_t;

    // One in-flight pixel: the config it was sampled under travels with it.
    typedef struct packed {
        logic             video_on;
        logic [PIX_W-1:0] icon0;
        logic [PIX_W-1:0] icon1;
        cfg_t             cfg;
        logic             blink_phase;
    } stage_t;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col);
        return {row[COORD_W-1:TILE_SHIFT], col[COORD_W-1:TILE_SHIFT]};
    endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// Bundle of the sequencer's timing-generator, BRAM, config and colorizer signals.
// master drives the sequencer inputs; slave is the sequencer's own view.
interface display_sequencer_if;
    import display_pkg::*;

    logic                 video_on_in;
    logic [COORD_W-1:0]   pixel_row;
    logic [COORD_W-1:0]   pixel_column;
    logic [PIX_W-1:0]     icon0_in;
    logic [PIX_W-1:0]     icon1_in;
    logic [ADDR_W-1:0]    world_addr;
    logic [PIX_W-1:0]     world_pixel_in;
    logic                 cfg_wr;
    logic [CFG_W-1:0]     cfg_data;
    logic                 cfg_pending;
    logic                 cfg_ack;
    logic                 video_on_out;
    logic [PIX_W-1:0]     world_pixel_out;
    logic [PIX_W-1:0]     icon_out;
    logic [FRAME_W-1:0]   frame_count;

    modport master (
        output video_on_in, pixel_row, pixel_column, icon0_in, icon1_in,
        output world_pixel_in, cfg_wr, cfg_data,
        input  world_addr, cfg_pending, cfg_ack, video_on_out, world_pixel_out,
        input  icon_out, frame_count
    );

    modport slave (
        input  video_on_in, pixel_row, pixel_column, icon0_in, icon1_in,
        input  world_pixel_in, cfg_wr, cfg_data,
        output world_addr, cfg_pending, cfg_ack, video_on_out, world_pixel_out,
        output icon_out, frame_count
    );

endinterface

// File: rtl/icon_arbiter.sv
// Combinational enable/blink masking and priority merge of the two icon layers.
module icon_arbiter
    import display_pkg::*;
(
    input  logic [PIX_W-1:0] icon0_i,
    input  logic [PIX_W-1:0] icon1_i,
    input  cfg_t             cfg_i,
    input  logic             blink_phase_i,
    output logic [PIX_W-1:0] icon_o
);

    logic [PIX_W-1:0] eff0;
    logic [PIX_W-1:0] eff1;
    logic             icon1_hidden;

    assign icon1_hidden = cfg_i.icon1_blink & blink_phase_i;
    assign eff0 = cfg_i.icon0_en ? icon0_i : '0;
    assign eff1 = (cfg_i.icon1_en && !icon1_hidden) ? icon1_i : '0;

    always_comb begin
        icon_o = '0;
        if ((eff0 != '0) && (eff1 != '0)) begin
            icon_o = cfg_i.prio ? eff1 : eff0;
        end else if (eff0 != '0) begin
            icon_o = eff0;
        end else begin
            icon_o = eff1;
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Three-stage pixel pipeline aligning world-map BRAM data with icon layers,
// plus frame detection and a frame-synchronous config shadow register.
module display_sequencer
    import display_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               video_on_in,
    input  logic [COORD_W-1:0] pixel_row,
    input  logic [COORD_W-1:0] pixel_column,
    input  logic [PIX_W-1:0]   icon0_in,
    input  logic [PIX_W-1:0]   icon1_in,
    output logic [ADDR_W-1:0]  world_addr,
    input  logic [PIX_W-1:0]   world_pixel_in,
    input  logic               cfg_wr,
    input  logic [CFG_W-1:0]   cfg_data,
    output logic               cfg_pending,
    output logic               cfg_ack,
    output logic               video_on_out,
    output logic [PIX_W-1:0]   world_pixel_out,
    output logic [PIX_W-1:0]   icon_out,
    output logic [FRAME_W-1:0] frame_count
);

    logic               frame_cond;
    logic               frame_tick;
    logic               frame_seen_q,   frame_seen_d;
    logic [ADDR_W-1:0]  world_addr_q,   world_addr_d;
    stage_t             s1_q,           s1_d;
    stage_t             s2_q,           s2_d;
    logic               video_on_q,     video_on_d;
    logic [PIX_W-1:0]   world_pixel_q,  world_pixel_d;
    logic [PIX_W-1:0]   icon_q,         icon_d;
    logic [PIX_W-1:0]   arb_icon;
    logic [FRAME_W-1:0] frame_count_q,  frame_count_d;
    cfg_t               cfg_active_q,   cfg_active_d;
    cfg_t               cfg_shadow_q,   cfg_shadow_d;
    logic               cfg_pending_q,  cfg_pending_d;
    logic               cfg_ack_q,      cfg_ack_d;

    assign frame_cond = video_on_in && (pixel_row == '0) && (pixel_column == '0);
    assign frame_tick = frame_cond && !frame_seen_q;

    // Arbitration happens at the last stage, under the config captured at stage 1.
    icon_arbiter u_icon_arbiter (
        .icon0_i       (s2_q.icon0),
        .icon1_i       (s2_q.icon1),
        .cfg_i         (s2_q.cfg),
        .blink_phase_i (s2_q.blink_phase),
        .icon_o        (arb_icon)
    );

    always_comb begin
        frame_seen_d     = frame_cond;
        world_addr_d     = tile_addr(pixel_row, pixel_column);

        s1_d             = '0;
        s1_d.video_on    = video_on_in;
        s1_d.icon0       = icon0_in;
        s1_d.icon1       = icon1_in;
        s1_d.cfg         = cfg_active_q;
        s1_d.blink_phase = frame_count_q[BLINK_BIT];
        s2_d             = s1_q;

        video_on_d       = s2_q.video_on;
        world_pixel_d    = s2_q.video_on ? world_pixel_in : '0;
        icon_d           = s2_q.video_on ? arb_icon : '0;

        frame_count_d    = frame_count_q + FRAME_W'(frame_tick);
    end

    // Apply first, then capture: a write coinciding with the tick stays pending.
    always_comb begin
        cfg_active_d  = cfg_active_q;
        cfg_shadow_d  = cfg_shadow_q;
        cfg_pending_d = cfg_pending_q;
        cfg_ack_d     = 1'b0;
        if (frame_tick && cfg_pending_q) begin
            cfg_active_d  = cfg_shadow_q;
            cfg_pending_d = 1'b0;
            cfg_ack_d     = 1'b1;
        end
        if (cfg_wr) begin
            cfg_shadow_d  = cfg_t'(cfg_data);
            cfg_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_seen_q  <= 1'b0;
            world_addr_q  <= '0;
            s1_q          <= '0;
            s2_q          <= '0;
            video_on_q    <= 1'b0;
            world_pixel_q <= '0;
            icon_q        <= '0;
            frame_count_q <= '0;
            cfg_active_q  <= cfg_t'(CFG_RESET);
            cfg_shadow_q  <= cfg_t'(SHADOW_RST);
            cfg_pending_q <= 1'b0;
            cfg_ack_q     <= 1'b0;
        end else begin
            frame_seen_q  <= frame_seen_d;
            world_addr_q  <= world_addr_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            video_on_q    <= video_on_d;
            world_pixel_q <= world_pixel_d;
            icon_q        <= icon_d;
            frame_count_q <= frame_count_d;
            cfg_active_q  <= cfg_active_d;
            cfg_shadow_q  <= cfg_shadow_d;
            cfg_pending_q <= cfg_pending_d;
            cfg_ack_q     <= cfg_ack_d;
        end
    end

    assign world_addr      = world_addr_q;
    assign video_on_out    = video_on_q;
    assign world_pixel_out = world_pixel_q;
    assign icon_out        = icon_q;
    assign frame_count     = frame_count_q;
    assign cfg_pending     = cfg_pending_q;
    assign cfg_ack         = cfg_ack_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized bench for display_sequencer against a frame/config transaction model.
module tb_display_sequencer;
    import display_pkg::*;

    typedef struct packed {
        logic       v;
        logic [1:0] wp;
        logic [1:0] ic;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    display_sequencer_if dif ();

    display_sequencer dut (
        .clk             (clk),
        .resetn          (resetn),
        .video_on_in     (dif.video_on_in),
        .pixel_row       (dif.pixel_row),
        .pixel_column    (dif.pixel_column),
        .icon0_in        (dif.icon0_in),
        .icon1_in        (dif.icon1_in),
        .world_addr      (dif.world_addr),
        .world_pixel_in  (dif.world_pixel_in),
        .cfg_wr          (dif.cfg_wr),
        .cfg_data        (dif.cfg_data),
        .cfg_pending     (dif.cfg_pending),
        .cfg_ack         (dif.cfg_ack),
        .video_on_out    (dif.video_on_out),
        .world_pixel_out (dif.world_pixel_out),
        .icon_out        (dif.icon_out),
        .frame_count     (dif.frame_count)
    );

    // World-map BRAM with one-cycle synchronous read.
    logic [1:0] bram [0:16383];
    always @(posedge clk) dif.world_pixel_in <= bram[dif.world_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int acks_seen = 0;

    // Reference state: frames and config as the rules describe them.
    int         m_fc;
    logic [3:0] m_active;
    logic [3:0] m_shadow;
    bit         m_pending;
    bit         m_prev_cond;
    exp_t       q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fc        = 0;
        m_active    = 4'b0011;
        m_shadow    = 4'b0000;
        m_pending   = 0;
        m_prev_cond = 0;
        q.delete();
        // Pipeline holds two cleared pixels ahead of the first real one.
        q.push_back('0);
        q.push_back('0);
    endtask

    task automatic step(input bit vo, input logic [9:0] row, input logic [9:0] col,
                        input logic [1:0] i0, input logic [1:0] i1,
                        input bit wr, input logic [3:0] data);
        bit          cond, tick, exp_ack;
        logic [13:0] a;
        logic [1:0]  e0, e1;
        exp_t        e;
        dif.video_on_in  = vo;
        dif.pixel_row    = row;
        dif.pixel_column = col;
        dif.icon0_in     = i0;
        dif.icon1_in     = i1;
        dif.cfg_wr       = wr;
        dif.cfg_data     = data;

        cond = vo && (row == 0) && (col == 0);
        tick = cond && !m_prev_cond;
        a    = row / 8 * 128 + col / 8;
        e0   = m_active[0] ? i0 : 2'd0;
        e1   = (m_active[1] && !(m_active[3] && ((m_fc / 32) % 2 == 1))) ? i1 : 2'd0;
        e.v  = vo;
        if (!vo) begin
            e.wp = 0;
            e.ic = 0;
        end else begin
            e.wp = bram[a];
            if (e0 != 0 && e1 != 0) e.ic = m_active[2] ? e1 : e0;
            else                    e.ic = (e0 != 0) ? e0 : e1;
        end
        q.push_back(e);

        exp_ack = tick && m_pending;
        if (exp_ack) begin
            m_active  = m_shadow;
            m_pending = 0;
        end
        if (wr) begin
            m_shadow  = data;
            m_pending = 1;
        end
        if (tick) m_fc = (m_fc + 1) % 256;
        m_prev_cond = cond;

        @(posedge clk);
        #1;
        check_val("world_addr", dif.world_addr, a);
        check_val("cfg_pending", dif.cfg_pending, m_pending);
        check_val("cfg_ack", dif.cfg_ack, exp_ack);
        check_val("frame_count", dif.frame_count, m_fc);
        if (dif.cfg_ack) acks_seen++;
        if (q.size() >= 3) begin
            e = q.pop_front();
            check_val("video_on_out", dif.video_on_out, e.v);
            check_val("world_pixel_out", dif.world_pixel_out, e.wp);
            check_val("icon_out", dif.icon_out, e.ic);
        end
        dif.cfg_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1, 10'($urandom_range(1, 479)), 10'($urandom_range(0, 639)),
                 2'($urandom), 2'($urandom), 0, 4'd0);
    endtask

    task automatic frame_start(input bit wr, input logic [3:0] data);
        step(1, 10'd0, 10'd0, 2'($urandom), 2'($urandom), wr, data);
    endtask

    task automatic write_cfg(input logic [3:0] data);
        step(1, 10'($urandom_range(1, 479)), 10'($urandom_range(0, 639)), 0, 0, 1, data);
    endtask

    // Sample one icon pair, let it drain to the output, and check the merged value.
    task automatic pixel(input string tag, input logic [1:0] i0, input logic [1:0] i1,
                         input logic [1:0] exp);
        step(1, 10'($urandom_range(1, 479)), 10'($urandom_range(0, 639)), i0, i1, 0, 4'd0);
        idle(2);
        check_val(tag, dif.icon_out, exp);
    endtask

    initial begin
        int acks0, vis, supp;
        for (int i = 0; i < 16384; i++) bram[i] = 2'($urandom_range(0, 3));
        bram[14'h0105] = 2'd2;

        resetn = 1'b0;
        dif.video_on_in = 0; dif.pixel_row = 0; dif.pixel_column = 0;
        dif.icon0_in = 0; dif.icon1_in = 0; dif.cfg_wr = 0; dif.cfg_data = 0;
        model_reset();
        #2;
        check_val("rst_video_on_out", dif.video_on_out, 0);
        check_val("rst_world_addr", dif.world_addr, 0);
        check_val("rst_frame_count", dif.frame_count, 0);
        check_val("rst_cfg_pending", dif.cfg_pending, 0);
        @(posedge clk); @(posedge clk); #3;
        resetn = 1'b1;

        // Tile addressing and BRAM alignment.
        step(1, 10'd17, 10'd42, 0, 0, 0, 4'd0);
        check_val("addr_17_42", dif.world_addr, 14'h0105);
        idle(2);
        check_val("world_pixel_17_42", dif.world_pixel_out, 2);

        // Priority switch applied at a frame boundary.
        pixel("prio0_icon", 2'd1, 2'd2, 2'd1);
        write_cfg(4'b0111);
        pixel("prio_not_yet", 2'd1, 2'd2, 2'd1);
        frame_start(0, 4'd0);
        pixel("prio1_icon", 2'd1, 2'd2, 2'd2);
        pixel("both_clear", 2'd0, 2'd0, 2'd0);

        // Last write wins; exactly one ack on apply.
        acks0 = acks_seen;
        write_cfg(4'b0001);
        idle(1);
        write_cfg(4'b0110);
        check_val("pending_after_writes", dif.cfg_pending, 1);
        pixel("old_cfg_held", 2'd3, 2'd0, 2'd3);
        frame_start(0, 4'd0);
        pixel("new_cfg_icon0_off", 2'd3, 2'd0, 2'd0);
        pixel("new_cfg_icon1_wins", 2'd1, 2'd2, 2'd2);
        check_val("single_ack", acks_seen - acks0, 1);

        // Write coinciding with tick while pending.
        acks0 = acks_seen;
        write_cfg(4'b0011);
        idle(1);
        frame_start(1, 4'b0101);
        check_val("pending_kept_on_coincide", dif.cfg_pending, 1);
        pixel("old_shadow_applied", 2'd0, 2'd2, 2'd2);
        frame_start(0, 4'd0);
        pixel("new_shadow_applied", 2'd0, 2'd2, 2'd0);
        check_val("two_acks", acks_seen - acks0, 2);

        // Random traffic checked entirely by the model.
        for (int k = 0; k < 500; k++) begin
            bit at_origin;
            at_origin = ($urandom_range(0, 39) == 0);
            step(($urandom_range(0, 7) != 0),
                 at_origin ? 10'd0 : 10'($urandom_range(0, 479)),
                 at_origin ? 10'd0 : 10'($urandom_range(0, 639)),
                 2'($urandom), 2'($urandom),
                 ($urandom_range(0, 29) == 0), 4'($urandom));
        end
        idle(2);

        // Blink over 64 frames.
        write_cfg(4'b1011);
        idle(1);
        frame_start(0, 4'd0);
        idle(1);
        vis = 0;
        supp = 0;
        for (int f = 0; f < 64; f++) begin
            frame_start(0, 4'd0);
            idle(1);
            pixel("blink_phase", 2'd0, 2'd3, ((m_fc / 32) % 2 == 1) ? 2'd0 : 2'd3);
            if (dif.icon_out == 2'd3) vis++;
            else                      supp++;
        end
        check_val("blink_visible_frames", vis, 32);
        check_val("blink_hidden_frames", supp, 32);

        // Frame counter wrap.
        while (m_fc != 255) begin
            frame_start(0, 4'd0);
            idle(1);
        end
        check_val("frame_count_255", dif.frame_count, 255);
        frame_start(0, 4'd0);
        check_val("frame_count_wrap", dif.frame_count, 0);
        idle(3);
        check_val("no_extra_tick", dif.frame_count, 0);

        // Reset mid-line with config pending.
        write_cfg(4'b0110);
        step(1, 10'd100, 10'd200, 2'd3, 2'd3, 0, 4'd0);
        #2;
        resetn = 1'b0;
        #1;
        check_val("midrst_video_on_out", dif.video_on_out, 0);
        check_val("midrst_world_pixel", dif.world_pixel_out, 0);
        check_val("midrst_icon_out", dif.icon_out, 0);
        check_val("midrst_world_addr", dif.world_addr, 0);
        check_val("midrst_frame_count", dif.frame_count, 0);
        check_val("midrst_cfg_pending", dif.cfg_pending, 0);
        check_val("midrst_cfg_ack", dif.cfg_ack, 0);
        model_reset();
        @(posedge clk);
        #3;
        resetn = 1'b1;
        pixel("post_rst_cfg_both_en", 2'd1, 2'd2, 2'd1);
        pixel("post_rst_cfg_icon1", 2'd0, 2'd2, 2'd2);
        frame_start(0, 4'd0);
        pixel("post_rst_pending_dropped", 2'd1, 2'd2, 2'd1);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_sequencer.md
DISPLAY_SEQUENCER -- requirements
Module: display_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state on rising edge.
REQ-002 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: video_on_in  input  1  DTG visible-region flag for the current coordinate.
REQ-004 SHALL have port: pixel_row  input  10  DTG row (0..479).
REQ-005 SHALL have port: pixel_column  input  10  DTG column (0..639).
REQ-006 SHALL have port: icon0_in  input  2  robot icon pixel for the current coordinate; 0 = transparent.
REQ-007 SHALL have port: icon1_in  input  2  target icon pixel for the current coordinate; 0 = transparent.
REQ-008 SHALL have port: world_addr  output  14  world-map BRAM read address, registered.
REQ-009 SHALL have port: world_pixel_in  input  2  BRAM data; one-cycle synchronous read latency.
REQ-010 SHALL have port: cfg_wr  input  1  single-cycle config write strobe.
REQ-011 SHALL have port: cfg_data  input  4  [0] icon0_en, [1] icon1_en, [2] prio (0 = icon0 wins, 1 = icon1 wins), [3] icon1_blink.
REQ-012 SHALL have port: cfg_pending  output  1  a written config awaits the frame boundary.
REQ-013 SHALL have port: cfg_ack  output  1  one-cycle pulse when pending config becomes active.
REQ-014 SHALL have port: video_on_out, world_pixel_out[1:0], icon_out[1:0]  output  colorizer feed, aligned.
REQ-015 SHALL have port: frame_count  output  8  frames since reset; wraps 255 -> 0.

Function
REQ-016 SHALL register world_addr = {pixel_row[9:3], pixel_column[9:3]} one cycle after sampling the coordinates (8x8 pixel tiles, 128x128 map).
REQ-017 SHALL sample world_pixel_in two cycles after the coordinates and present all colorizer outputs registered with a fixed latency of 3 cycles from coordinate sampling.
REQ-018 SHALL delay video_on_in, icon0_in, and icon1_in through 3-stage registers so that they align with world_pixel_out.
REQ-019 SHALL force world_pixel_out = 0 and icon_out = 0 whenever the delayed video_on is 0.
REQ-020 SHALL treat a disabled icon as transparent (0).
REQ-021 SHALL treat icon1 as transparent when icon1_blink = 1 and frame_count[5] = 1 (32-frame blink period).
REQ-022 SHALL drive icon_out with the single non-zero effective icon when exactly one is non-zero, with the prio winner when both are non-zero, and with 0 when both are zero.
REQ-023 SHALL generate frame_tick for exactly one cycle on the first cycle that samples video_on_in = 1, pixel_row = 0, and pixel_column = 0 after that condition was false, using edge detection.
REQ-024 SHALL increment frame_count on each frame_tick, with modulo-256 wrap.
REQ-025 SHALL load cfg_data into the shadow register and set cfg_pending on cfg_wr; a further cfg_wr while pending overwrites the shadow (last write wins).
REQ-026 SHALL, on frame_tick with cfg_pending = 1, copy shadow to the active config, clear cfg_pending, and pulse cfg_ack the following cycle.
REQ-027 SHALL, when cfg_wr and frame_tick coincide, apply the previous shadow if one is pending, keep cfg_pending = 1 holding the new data, and apply the new data at the next frame_tick.
REQ-028 SHALL make config changes effective on pixels sampled after the apply edge; in-flight pipeline pixels keep the config that was active when they were sampled at stage 1.

Reset
REQ-029 SHALL, while resetn = 0, asynchronously clear every pipeline stage, world_addr, outputs, frame_count, cfg_pending, cfg_ack, and the frame-tick edge detector.
REQ-030 SHALL reset the active config to 4'b0011 (both icons enabled, icon0 priority, no blink) and the shadow to 4'b0000.
REQ-031 SHALL discard any pending config if reset is asserted mid-frame, and resume correct alignment 3 cycles after the first post-reset sample.

Structure
REQ-032 SHALL take from shared package display_pkg: cfg bit indices, PIPE_LATENCY = 3, TILE_SHIFT = 3, address widths, and CFG_RESET = 4'b0011.
REQ-033 SHALL implement the priority/enable/blink merge as combinational sub-module icon_arbiter; the pipeline, frame detection, and config shadow stay in display_sequencer.

Verification
REQ-034 SHALL cover: row = 17, column = 42, video_on = 1 -> world_addr = 14'h0105 one cycle later; world_pixel_in = 2 returned -> world_pixel_out = 2 three cycles after sampling.
REQ-035 SHALL cover: icon0 = 1 and icon1 = 2 with prio = 0 -> icon_out = 1; after a prio = 1 write and frame_tick -> icon_out = 2; icon0 = 0 and icon1 = 0 -> icon_out = 0.
REQ-036 SHALL cover: two cfg_wr writes (4'b0001 then 4'b0110) mid-frame -> cfg_pending = 1, the active config unchanged until frame_tick, then active = 4'b0110 and cfg_ack pulses once.
REQ-037 SHALL cover: cfg_wr coincident with frame_tick while pending -> the old shadow applies now, the new one at the next tick, with two cfg_ack pulses total.
REQ-038 SHALL cover: icon1_blink = 1 over 64 frames -> icon1 visible in frames 0-31 and suppressed in frames 32-63; frame_count wraps 255 -> 0 without an extra tick.
REQ-039 SHALL cover: resetn pulsed low mid-line with a config pending -> all outputs 0 immediately, active config = 4'b0011, and cfg_pending = 0.
